// File: rtl/mod_wb_arbiter_if.sv
// Writeback bus between the ALU/load requesters, the arbiter and the register file.
// The slave modport is the arbiter's view; the master modport is the requester/observer view.
interface mod_wb_arbiter_if #(
    parameter int DATA_W    = 64,
    parameter int NREGS     = 16,
    parameter int REG_IDX_W = 4
);
    logic                 alu_valid;
    logic                 alu_ready;
    logic                 alu_dual;
    logic [REG_IDX_W-1:0] alu_dst0;
    logic [DATA_W-1:0]    alu_data0;
    logic [REG_IDX_W-1:0] alu_dst1;
    logic [DATA_W-1:0]    alu_data1;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [REG_IDX_W-1:0] mem_dst;
    logic [DATA_W-1:0]    mem_data;
    logic                 rf_we;
    logic [REG_IDX_W-1:0] rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;
    logic [NREGS-1:0]     busy_mask;
    logic                 wb_done;

    modport slave (
        input  alu_valid, alu_dual, alu_dst0, alu_data0, alu_dst1, alu_data1,
        input  mem_valid, mem_dst, mem_data,
        output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, busy_mask, wb_done
    );

    modport master (
        output alu_valid, alu_dual, alu_dst0, alu_data0, alu_dst1, alu_data1,
        output mem_valid, mem_dst, mem_data,
        input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, busy_mask, wb_done
    );
endinterface

// File: rtl/mod_wb_arbiter.sv
// Single-port register-file writeback sequencer: round-robin between ALU and load results,
// splitting dual-destination ALU results into two back-to-back writes.
module mod_wb_arbiter #(
    parameter int DATA_W    = 64,
    parameter int NREGS     = 16,
    parameter int REG_IDX_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    mod_wb_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE0 = 2'd1, WRITE1 = 2'd2} state_t;
    localparam logic RR_MEM = 1'b0;
    localparam logic RR_ALU = 1'b1;

    state_t               r_state, w_state_nxt;
    logic                 r_rr_last;
    logic                 r_dual;
    logic [REG_IDX_W-1:0] r_dst1;
    logic [DATA_W-1:0]    r_data1;
    logic [REG_IDX_W-1:0] r_waddr;
    logic [DATA_W-1:0]    r_wdata;
    logic [NREGS-1:0]     r_busy, w_busy_nxt;
    logic                 w_can_accept, w_we, w_done;
    logic                 w_grant_alu, w_grant_mem, w_acc_alu, w_acc_mem;

    // Contention goes to whichever side was not granted last.
    assign w_grant_alu = bus.alu_valid & (~bus.mem_valid | (r_rr_last == RR_MEM));
    assign w_grant_mem = bus.mem_valid & (~bus.alu_valid | (r_rr_last == RR_ALU));
    assign w_acc_alu   = reset & w_can_accept & w_grant_alu;
    assign w_acc_mem   = reset & w_can_accept & w_grant_mem;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (w_acc_alu | w_acc_mem)         w_state_nxt = WRITE0;
        else if (r_state == WRITE0 && r_dual) w_state_nxt = WRITE1;
    end

    always_comb begin
        w_can_accept = 1'b0;
        w_we         = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE:   w_can_accept = 1'b1;
            WRITE0: begin
                w_we         = 1'b1;
                w_can_accept = ~r_dual;
                w_done       = ~r_dual;
            end
            WRITE1: begin
                w_we         = 1'b1;
                w_can_accept = 1'b1;
                w_done       = 1'b1;
            end
            default: ;
        endcase
    end

    // The first write of a same-register dual keeps the bit busy until the second lands.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_we && !(r_state == WRITE0 && r_dual && r_dst1 == r_waddr))
            w_busy_nxt[r_waddr] = 1'b0;
        if (w_acc_alu) begin
            w_busy_nxt[bus.alu_dst0] = 1'b1;
            if (bus.alu_dual) w_busy_nxt[bus.alu_dst1] = 1'b1;
        end
        if (w_acc_mem) w_busy_nxt[bus.mem_dst] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_last <= RR_MEM;
            r_dual    <= 1'b0;
            r_dst1    <= '0;
            r_data1   <= '0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_busy    <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_acc_alu) begin
                r_rr_last <= RR_ALU;
                r_waddr   <= bus.alu_dst0;
                r_wdata   <= bus.alu_data0;
                r_dual    <= bus.alu_dual;
                r_dst1    <= bus.alu_dst1;
                r_data1   <= bus.alu_data1;
            end else if (w_acc_mem) begin
                r_rr_last <= RR_MEM;
                r_waddr   <= bus.mem_dst;
                r_wdata   <= bus.mem_data;
                r_dual    <= 1'b0;
            end else if (r_state == WRITE0 && r_dual) begin
                r_waddr   <= r_dst1;
                r_wdata   <= r_data1;
            end
        end
    end

    assign bus.alu_ready = w_acc_alu;
    assign bus.mem_ready = w_acc_mem;
    assign bus.rf_we     = w_we;
    assign bus.rf_waddr  = r_waddr;
    assign bus.rf_wdata  = r_wdata;
    assign bus.busy_mask = r_busy;
    assign bus.wb_done   = w_done;
endmodule

// File: tb/tb_mod_wb_arbiter.sv
// Directed bench for mod_wb_arbiter: reset, single/dual writes, contention and reset mid-dual.
module tb_mod_wb_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mod_wb_arbiter_if #(.DATA_W(64), .NREGS(16), .REG_IDX_W(4)) bus ();

    mod_wb_arbiter #(.DATA_W(64), .NREGS(16), .REG_IDX_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_dual = 1'b0;
        bus.alu_dst0 = '0; bus.alu_data0 = '0; bus.alu_dst1 = '0; bus.alu_data1 = '0;
        bus.mem_valid = 1'b0; bus.mem_dst = '0; bus.mem_data = '0;
    endtask

    task automatic alu_req(input logic dual, input logic [3:0] d0, input logic [63:0] v0,
                           input logic [3:0] d1, input logic [63:0] v1);
        bus.alu_valid = 1'b1; bus.alu_dual = dual;
        bus.alu_dst0 = d0; bus.alu_data0 = v0; bus.alu_dst1 = d1; bus.alu_data1 = v1;
    endtask

    initial begin
        logic exp_mem;
        idle_inputs();
        // Reset with both requesters asserting
        alu_req(1'b0, 4'd6, 64'h66, 4'd0, 64'h0);
        bus.mem_valid = 1'b1; bus.mem_dst = 4'd9; bus.mem_data = 64'h99;
        repeat (3) begin
            edge1();
            chk("rst_we", bus.rf_we, 0);
            chk("rst_busy", bus.busy_mask, 0);
            chk("rst_alu_rdy", bus.alu_ready, 0);
            chk("rst_mem_rdy", bus.mem_ready, 0);
        end
        chk("rst_waddr", bus.rf_waddr, 0);
        chk("rst_wdata", bus.rf_wdata, 0);
        chk("rst_done", bus.wb_done, 0);

        // Single ALU write to r3
        reset = 1'b1;
        idle_inputs();
        alu_req(1'b0, 4'd3, 64'h1122, 4'd0, 64'h0);
        #1;
        chk("s_alu_rdy", bus.alu_ready, 1);
        chk("s_mem_rdy", bus.mem_ready, 0);
        edge1();
        idle_inputs();
        chk("s_we", bus.rf_we, 1);
        chk("s_waddr", bus.rf_waddr, 3);
        chk("s_wdata", bus.rf_wdata, 64'h1122);
        chk("s_done", bus.wb_done, 1);
        chk("s_busy", bus.busy_mask, 16'h0008);
        edge1();
        chk("s_we_after", bus.rf_we, 0);
        chk("s_done_after", bus.wb_done, 0);
        chk("s_busy_after", bus.busy_mask, 0);
        chk("s_waddr_hold", bus.rf_waddr, 3);
        chk("s_wdata_hold", bus.rf_wdata, 64'h1122);

        // Dual write r0 then r2; both readies low during the first write
        alu_req(1'b1, 4'd0, 64'hAAAA, 4'd2, 64'hBBBB);
        #1;
        chk("d_alu_rdy", bus.alu_ready, 1);
        edge1();
        alu_req(1'b0, 4'd11, 64'h11, 4'd0, 64'h0);
        bus.mem_valid = 1'b1; bus.mem_dst = 4'd12; bus.mem_data = 64'h12;
        #1;
        chk("d_alu_rdy_w0", bus.alu_ready, 0);
        chk("d_mem_rdy_w0", bus.mem_ready, 0);
        chk("d_we0", bus.rf_we, 1);
        chk("d_waddr0", bus.rf_waddr, 0);
        chk("d_wdata0", bus.rf_wdata, 64'hAAAA);
        chk("d_done0", bus.wb_done, 0);
        chk("d_busy0", bus.busy_mask, 16'h0005);
        idle_inputs();
        edge1();
        chk("d_we1", bus.rf_we, 1);
        chk("d_waddr1", bus.rf_waddr, 2);
        chk("d_wdata1", bus.rf_wdata, 64'hBBBB);
        chk("d_done1", bus.wb_done, 1);
        chk("d_busy1", bus.busy_mask, 16'h0004);
        edge1();
        chk("d_we_after", bus.rf_we, 0);
        chk("d_busy_after", bus.busy_mask, 0);

        // Contention: ALU was granted last, so MEM leads and grants alternate
        for (int k = 0; k < 6; k++) begin
            alu_req(1'b0, 4'd1, 64'h100 + 64'(k), 4'd0, 64'h0);
            bus.mem_valid = 1'b1; bus.mem_dst = 4'd7; bus.mem_data = 64'h700 + 64'(k);
            exp_mem = (k % 2 == 0);
            #1;
            chk("c_mem_rdy", bus.mem_ready, exp_mem);
            chk("c_alu_rdy", bus.alu_ready, !exp_mem);
            edge1();
            chk("c_we", bus.rf_we, 1);
            chk("c_waddr", bus.rf_waddr, exp_mem ? 4'd7 : 4'd1);
            chk("c_wdata", bus.rf_wdata, exp_mem ? 64'h700 + 64'(k) : 64'h100 + 64'(k));
            chk("c_done", bus.wb_done, 1);
            chk("c_busy", bus.busy_mask, exp_mem ? 16'h0080 : 16'h0002);
        end
        idle_inputs();
        edge1();
        chk("c_we_after", bus.rf_we, 0);
        chk("c_busy_after", bus.busy_mask, 0);

        // Back-to-back singles to r4: set wins over clear
        alu_req(1'b0, 4'd4, 64'h41, 4'd0, 64'h0);
        edge1();
        alu_req(1'b0, 4'd4, 64'h42, 4'd0, 64'h0);
        #1;
        chk("b_alu_rdy", bus.alu_ready, 1);
        chk("b_busy0", bus.busy_mask, 16'h0010);
        chk("b_wdata0", bus.rf_wdata, 64'h41);
        edge1();
        idle_inputs();
        chk("b_busy1", bus.busy_mask, 16'h0010);
        chk("b_wdata1", bus.rf_wdata, 64'h42);
        chk("b_done1", bus.wb_done, 1);
        edge1();
        chk("b_busy_after", bus.busy_mask, 0);

        // Same-register dual on r5
        alu_req(1'b1, 4'd5, 64'h1, 4'd5, 64'h2);
        edge1();
        idle_inputs();
        chk("sr_waddr0", bus.rf_waddr, 5);
        chk("sr_wdata0", bus.rf_wdata, 64'h1);
        chk("sr_busy0", bus.busy_mask, 16'h0020);
        chk("sr_done0", bus.wb_done, 0);
        edge1();
        chk("sr_waddr1", bus.rf_waddr, 5);
        chk("sr_wdata1", bus.rf_wdata, 64'h2);
        chk("sr_busy1", bus.busy_mask, 16'h0020);
        chk("sr_done1", bus.wb_done, 1);
        edge1();
        chk("sr_busy_after", bus.busy_mask, 0);
        chk("sr_we_after", bus.rf_we, 0);

        // Reset during the first half of a dual
        alu_req(1'b1, 4'd8, 64'h88, 4'd9, 64'h99);
        edge1();
        idle_inputs();
        chk("rd_we0", bus.rf_we, 1);
        chk("rd_waddr0", bus.rf_waddr, 8);
        chk("rd_busy0", bus.busy_mask, 16'h0300);
        reset = 1'b0;
        edge1();
        chk("rd_we", bus.rf_we, 0);
        chk("rd_busy", bus.busy_mask, 0);
        chk("rd_done", bus.wb_done, 0);
        chk("rd_waddr", bus.rf_waddr, 0);
        reset = 1'b1;
        edge1();
        chk("rd_we_after", bus.rf_we, 0);
        chk("rd_waddr_after", bus.rf_waddr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
